// File: rtl/key_poll_pkg.sv
// Shared types and helpers for the Avalon-MM key polling master.
package key_poll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } poll_state_e;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One-key debouncer: a change is accepted after DEBOUNCE_N identical samples.
module key_debounce_cell
    import key_poll_pkg::*;
#(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_i,
    input  logic update_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);
    localparam int CNT_W = cnt_width(DEBOUNCE_N);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_N - 1);

    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_comb begin
        last_d  = last_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (update_i) begin
            last_d = sample_i;
            if (sample_i != last_q) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((cnt_d == CNT_MAX) && (sample_i != state_q)) begin
                state_d = sample_i;
                press_d = sample_i;
                rel_d   = ~sample_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/key_poll_master.sv
// Polls the key PIO data register at a fixed rate and debounces every key.
// state  | meaning
// IDLE   | waiting for the poll tick
// REQ    | read command presented, held through waitrequest
// WAIT   | command accepted, waiting for readdatavalid or timeout
// UPDATE | captured sample fed to the debouncers
module key_poll_master
    import key_poll_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int POLL_DIV   = 50000,
    parameter int DEBOUNCE_N = 4,
    parameter int TIMEOUT    = 64,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [1:0]          avm_address,
    output logic                avm_read,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid,
    input  logic [31:0]         avm_readdata,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                poll_error,
    input  logic                err_clr
);
    localparam int TICK_W = cnt_width(POLL_DIV);
    localparam int TO_W   = cnt_width(TIMEOUT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(POLL_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT - 1);

    poll_state_e         state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [NUM_KEYS-1:0] sample_q, sample_d;
    logic                err_q, err_d;
    logic                err_set;
    logic                tick;
    logic                update;
    logic [NUM_KEYS-1:0] sample_norm;
    logic                unused_readdata;

    assign unused_readdata = ^avm_readdata;
    assign sample_norm = ACTIVE_LOW ? ~avm_readdata[NUM_KEYS-1:0]
                                    : avm_readdata[NUM_KEYS-1:0];

    assign tick   = (tick_q == TICK_LAST);
    assign tick_d = tick ? '0 : tick_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        sample_d = sample_q;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) state_d = REQ;
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        sample_d = sample_norm;
                        state_d  = UPDATE;
                    end else begin
                        to_d    = TO_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (avm_readdatavalid) begin
                    sample_d = sample_norm;
                    state_d  = UPDATE;
                end else if (to_q == '0) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q - 1'b1;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A tick while a poll is still in flight is dropped, never queued.
        if (tick && (state_q != IDLE)) err_set = 1'b1;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            to_q     <= '0;
            sample_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            to_q     <= to_d;
            sample_q <= sample_d;
            err_q    <= err_d;
        end
    end

    assign update      = (state_q == UPDATE);
    assign avm_read    = (state_q == REQ);
    assign avm_address = PIO_DATA_ADDR;
    assign poll_error  = err_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_N(DEBOUNCE_N)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .sample_i (sample_q[k]),
            .update_i (update),
            .state_o  (key_state[k]),
            .press_o  (key_press[k]),
            .release_o(key_release[k])
        );
    end

endmodule

// File: doc/key_poll_master.md
# key_poll_master

Avalon-MM master that acts as the initiator for the read-only key input PIO slave. It polls the PIO data register (offset 0) at a fixed rate and debounces each key across consecutive samples. It then presents the debounced key state plus one-cycle press/release pulses to fabric logic, such as the synthesizer note-trigger path, with no Nios II software involvement. It sits between the system interconnect master port and the user logic.

## Interface
Parameters:
- NUM_KEYS, 4: keys sampled from readdata[NUM_KEYS-1:0]; range 1..32.
- POLL_DIV, 50000: clk cycles between poll launches (1 ms at 50 MHz); minimum 8.
- DEBOUNCE_N, 4: consecutive identical samples required to accept a change; range 1..15.
- TIMEOUT, 64: max cycles waiting for readdatavalid before abort.
- ACTIVE_LOW, 1: 1 = raw bit 0 means pressed (DE2-115 KEY buttons).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  reset; asynchronous and active-high, single clock domain.
- avm_address  out  2  always 2'd0 (PIO data register).
- avm_read  out  1  read request.
- avm_waitrequest  in  1  fabric stall; request held while high.
- avm_readdatavalid  in  1  read data valid.
- avm_readdata  in  32  read data; bits above NUM_KEYS ignored.
- key_state  out  NUM_KEYS  debounced state; 1 = pressed.
- key_press  out  NUM_KEYS  one-cycle pulse on debounced 0->1 transition.
- key_release  out  NUM_KEYS  one-cycle pulse on debounced 1->0 transition.
- poll_error  out  1  sticky flag, set on timeout or overrun; cleared by err_clr.
- err_clr  in  1  clears poll_error; set has priority if both occur in the same cycle.

## Operation
- Tick counter: free-running 0..POLL_DIV-1. `tick` asserts for one cycle when the count equals POLL_DIV-1, then the counter wraps to 0.
- FSM states:
  - IDLE: on tick, go to REQ.
  - REQ: avm_read=1. When avm_waitrequest=0 at a clock edge, the command is accepted; go to WAIT. A command accepted in the same cycle as readdatavalid is still handled correctly, going straight to UPDATE.
  - WAIT: avm_read=0. On readdatavalid, capture the sample and go to UPDATE. If the timeout counter reaches TIMEOUT, set poll_error and go to IDLE with the sample discarded.
  - UPDATE: run the debouncers for one cycle, then go to IDLE.
- Sample normalisation: sample = avm_readdata[NUM_KEYS-1:0] when ACTIVE_LOW=0, and the bitwise inverse of it when ACTIVE_LOW=1.
- Debounce, per key, evaluated only in UPDATE:
  - If the sample differs from the last sample, cnt=0.
  - Otherwise cnt saturates at DEBOUNCE_N-1.
  - When cnt reaches DEBOUNCE_N-1 and the sample differs from key_state, key_state takes the sample and the matching press/release pulse fires.
  - DEBOUNCE_N=1 accepts a change on the first sample.
- Overrun: a tick that arrives in any state other than IDLE is dropped and sets poll_error. The tick counter is never stalled.
- avm_address is constant 0. Exactly one outstanding read at a time.

## Timing
- Reset values: avm_read=0, avm_address=0, key_state=0, key_press=0, key_release=0, poll_error=0, FSM=IDLE, tick counter=0, last sample=0, cnt=0.
- Reset asserted mid-transaction: avm_read drops asynchronously. A readdatavalid that arrives after reset is released while in IDLE is ignored.
- First poll: tick occurs POLL_DIV cycles after reset release, and avm_read rises on the next edge.
- Latency against the PIO slave (registered readdata, zero wait states): tick edge, then REQ (1 cycle), then readdatavalid 1 cycle after acceptance, then UPDATE. Pulses and key_state change on the edge leaving UPDATE, 4 cycles after tick.
- A stable change is reported after DEBOUNCE_N consecutive polls showing the new value.
- Pulses are registered, exactly one cycle wide, and never overlap for the same key.

## Structure
- Package key_poll_pkg holds:
  - the FSM enum (IDLE, REQ, WAIT, UPDATE);
  - PIO_DATA_ADDR = 2'd0;
  - the counter width functions (clog2 of POLL_DIV, TIMEOUT, DEBOUNCE_N).
- Sub-module key_debounce_cell: one per key, generate-instantiated. Inputs are sample, an update strobe and DEBOUNCE_N; outputs are state, press and release.
- The top level contains the tick counter, FSM, timeout counter and error flag.

## Test plan
- Reset then idle keys: slave returns 0xF, ACTIVE_LOW=1, POLL_DIV=8, DEBOUNCE_N=4 -> key_state stays 0, no pulses, one read every 8 cycles with address 0.
- Press KEY1: readdata changes to 0xD and is held -> key_press=4'b0010 for exactly one cycle after the 4th 0xD poll; key_state=4'b0010; release gives the mirror key_release.
- Bounce: pattern 0xD,0xF,0xD,0xD,0xF -> no state change, no pulses.
- Waitrequest held high 5 cycles -> avm_read stays high and address stays 0 throughout; a single accepted read; data processed normally.
- Readdatavalid never returned, TIMEOUT=64 -> poll_error=1 after 64 WAIT cycles; FSM returns to IDLE; next tick polls normally; err_clr clears the flag.
- Assert reset during REQ -> avm_read=0 immediately with all outputs at reset values; a stale readdatavalid in the first cycles after reset release causes no pulse.
